// File: rtl/csi_rx_align_word_if.sv
// csi_rx_align_word_if -- bus between the per-lane byte aligners, the word
// aligner and the downstream packet handler.
//   bytes_in/bytes_vld   per-lane aligned bytes and their valids
//   packet_done          end-of-packet from the packet handler
//   wait_for_sync        aligners may lock to a new SYNC
//   lane_packet_done     per-lane packet_done back to the aligners
//   word_out/word_vld    lane-deskewed word and its valid
//   skew_err             one-cycle pulse on skew timeout or lock loss
// Modport master drives the aligner-facing inputs; slave is the word aligner.
interface csi_rx_align_word_if #(
    parameter int LANES = 2
);
    logic [8*LANES-1:0] bytes_in;
    logic [LANES-1:0]   bytes_vld;
    logic               packet_done;
    logic               wait_for_sync;
    logic [LANES-1:0]   lane_packet_done;
    logic [8*LANES-1:0] word_out;
    logic               word_vld;
    logic               skew_err;

    modport master (
        output bytes_in, bytes_vld, packet_done,
        input  wait_for_sync, lane_packet_done, word_out, word_vld, skew_err
    );

    modport slave (
        input  bytes_in, bytes_vld, packet_done,
        output wait_for_sync, lane_packet_done, word_out, word_vld, skew_err
    );
endinterface

// File: rtl/csi_rx_align_word.sv
// csi_rx_align_word -- CSI-2 multi-lane word aligner. Removes up to MAX_SKEW
// byte-clock cycles of inter-lane skew by delaying early lanes so every lane's
// first post-SYNC byte lands in the same output word.
// Ports:
//   clock   byte clock, rising edge
//   reset   synchronous, active-high
//   enable  clock enable; all state and outputs hold while low
//   bus     csi_rx_align_word_if slave (bytes in, deskewed word out, status)
module csi_rx_align_word #(
    parameter int LANES    = 2,
    parameter int MAX_SKEW = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    csi_rx_align_word_if.slave   bus
);
    // Counters must reach MAX_SKEW+1: a lane may arrive on the last ALIGN
    // cycle, giving the first lane a tap of MAX_SKEW+1.
    localparam int CW = $clog2(MAX_SKEW + 2);

    typedef enum logic [1:0] {IDLE, ALIGN, LOCKED} state_t;

    state_t                       state_q, state_d;
    logic [CW-1:0]                skew_q, skew_d;
    logic [LANES-1:0][CW-1:0]     tap_q, tap_d;
    logic [LANES-1:0][MAX_SKEW:0][7:0] dl_q;
    logic [8*LANES-1:0]           word_q, word_d, sel;
    logic                         vld_q, vld_d;
    logic                         err_q, err_d;
    logic                         all_vld, any_vld;

    assign all_vld = &bus.bytes_vld;
    assign any_vld = |bus.bytes_vld;

    // Delay line: dl_q[i][k] is lane i's byte from k+1 enable cycles ago.
    // Data path only, so no reset.
    always_ff @(posedge clock) begin
        if (enable) begin
            for (int i = 0; i < LANES; i++) begin
                dl_q[i][0] <= bus.bytes_in[8*i +: 8];
                for (int k = 1; k <= MAX_SKEW; k++) begin
                    dl_q[i][k] <= dl_q[i][k-1];
                end
            end
        end
    end

    // Tap 0 is the live input byte, tap k>0 is k cycles back. While aligning,
    // tap_q holds each lane's running valid count, which is exactly the tap
    // needed if the last lane arrives this cycle.
    always_comb begin
        sel = '0;
        for (int i = 0; i < LANES; i++) begin
            sel[8*i +: 8] = bus.bytes_in[8*i +: 8];
            for (int k = 0; k <= MAX_SKEW; k++) begin
                if (tap_q[i] == CW'(k + 1)) sel[8*i +: 8] = dl_q[i][k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        skew_d  = skew_q;
        tap_d   = tap_q;
        word_d  = word_q;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.packet_done && any_vld) begin
                    skew_d = '0;
                    if (all_vld) begin
                        state_d = LOCKED;
                        vld_d   = 1'b1;
                        word_d  = sel;
                    end else begin
                        state_d = ALIGN;
                        for (int i = 0; i < LANES; i++)
                            tap_d[i] = tap_q[i] + CW'(bus.bytes_vld[i]);
                    end
                end
            end
            ALIGN: begin
                if (bus.packet_done) begin
                    state_d = IDLE;
                    tap_d   = '0;
                    skew_d  = '0;
                end else if (all_vld) begin
                    state_d = LOCKED;
                    vld_d   = 1'b1;
                    word_d  = sel;
                end else if (skew_q == CW'(MAX_SKEW)) begin
                    // MAX_SKEW+1 ALIGN cycles without every lane: give up.
                    state_d = IDLE;
                    err_d   = 1'b1;
                    tap_d   = '0;
                    skew_d  = '0;
                end else begin
                    skew_d = skew_q + CW'(1);
                    for (int i = 0; i < LANES; i++)
                        tap_d[i] = tap_q[i] + CW'(bus.bytes_vld[i]);
                end
            end
            LOCKED: begin
                if (bus.packet_done) begin
                    state_d = IDLE;
                    tap_d   = '0;
                end else if (!all_vld) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    tap_d   = '0;
                end else begin
                    vld_d  = 1'b1;
                    word_d = sel;
                end
            end
            default: begin
                state_d = IDLE;
                tap_d   = '0;
                skew_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            skew_q  <= '0;
            tap_q   <= '0;
            word_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else if (enable) begin
            state_q <= state_d;
            skew_q  <= skew_d;
            tap_q   <= tap_d;
            word_q  <= word_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    assign bus.wait_for_sync    = (state_q != LOCKED);
    assign bus.lane_packet_done = {LANES{bus.packet_done | err_q}};
    assign bus.word_out         = word_q;
    assign bus.word_vld         = vld_q;
    assign bus.skew_err         = err_q;
endmodule

// File: tb/tb_csi_rx_align_word.sv
module tb_csi_rx_align_word;
    logic clock = 1'b0;
    logic reset;
    logic enable;
    int   checks = 0;
    int   errors = 0;

    csi_rx_align_word_if #(.LANES(2)) bus ();

    csi_rx_align_word #(.LANES(2), .MAX_SKEW(3)) dut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] b, input logic [1:0] v, input logic pd);
        bus.bytes_in    = b;
        bus.bytes_vld   = v;
        bus.packet_done = pd;
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        drive(16'h0, 2'b00, 1'b0);
        tick();
        tick();
        chk("rst_vld",  32'(bus.word_vld), 32'h0);
        chk("rst_err",  32'(bus.skew_err), 32'h0);
        chk("rst_wfs",  32'(bus.wait_for_sync), 32'h1);
        chk("rst_word", 32'(bus.word_out), 32'h0);
        chk("rst_lpd",  32'(bus.lane_packet_done), 32'h0);
        reset  = 1'b0;
        enable = 1'b1;

        // Both lanes arrive together
        drive(16'hB0A0, 2'b11, 1'b0); tick();
        chk("same_vld0",  32'(bus.word_vld), 32'h1);
        chk("same_word0", 32'(bus.word_out), 32'hB0A0);
        chk("same_wfs",   32'(bus.wait_for_sync), 32'h0);
        drive(16'hB1A1, 2'b11, 1'b0); tick();
        chk("same_word1", 32'(bus.word_out), 32'hB1A1);
        // packet_done wins over a simultaneous lane drop
        drive(16'hB2A2, 2'b01, 1'b1); #1;
        chk("pd_lpd_comb", 32'(bus.lane_packet_done), 32'h3);
        tick();
        chk("pd_vld",  32'(bus.word_vld), 32'h0);
        chk("pd_err",  32'(bus.skew_err), 32'h0);
        chk("pd_wfs",  32'(bus.wait_for_sync), 32'h1);
        chk("pd_hold", 32'(bus.word_out), 32'hB1A1);
        drive(16'h0, 2'b00, 1'b0); tick();

        // Lane0 two cycles ahead of lane1
        drive(16'h0010, 2'b01, 1'b0); tick();
        chk("skew_align_wfs", 32'(bus.wait_for_sync), 32'h1);
        chk("skew_align_vld", 32'(bus.word_vld), 32'h0);
        drive(16'h0011, 2'b01, 1'b0); tick();
        drive(16'h2012, 2'b11, 1'b0); tick();
        chk("skew_vld",   32'(bus.word_vld), 32'h1);
        chk("skew_word0", 32'(bus.word_out), 32'h2010);
        chk("skew_wfs",   32'(bus.wait_for_sync), 32'h0);
        drive(16'h2113, 2'b11, 1'b0); tick();
        chk("skew_word1", 32'(bus.word_out), 32'h2111);
        drive(16'h2214, 2'b11, 1'b0); tick();
        chk("skew_word2", 32'(bus.word_out), 32'h2212);

        // Enable low for three cycles: everything holds, even with garbage in
        enable = 1'b0;
        drive(16'h9999, 2'b00, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("en_word", 32'(bus.word_out), 32'h2212);
            chk("en_vld",  32'(bus.word_vld), 32'h1);
            chk("en_wfs",  32'(bus.wait_for_sync), 32'h0);
        end
        enable = 1'b1;
        drive(16'h2315, 2'b11, 1'b0); tick();
        chk("en_resume", 32'(bus.word_out), 32'h2313);

        // Lock loss: lane1 drops
        drive(16'h2416, 2'b01, 1'b0); tick();
        chk("loss_err",  32'(bus.skew_err), 32'h1);
        chk("loss_vld",  32'(bus.word_vld), 32'h0);
        chk("loss_wfs",  32'(bus.wait_for_sync), 32'h1);
        chk("loss_lpd",  32'(bus.lane_packet_done), 32'h3);
        chk("loss_hold", 32'(bus.word_out), 32'h2313);
        drive(16'h0, 2'b00, 1'b0); tick();
        chk("loss_err_clr", 32'(bus.skew_err), 32'h0);
        chk("loss_lpd_clr", 32'(bus.lane_packet_done), 32'h0);

        // Timeout: lane1 never arrives; error after 4 ALIGN cycles
        drive(16'h0050, 2'b01, 1'b0); tick();
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("to_early_err", 32'(bus.skew_err), 32'h0);
        end
        tick();
        chk("to_err", 32'(bus.skew_err), 32'h1);
        chk("to_lpd", 32'(bus.lane_packet_done), 32'h3);
        chk("to_wfs", 32'(bus.wait_for_sync), 32'h1);
        drive(16'h0, 2'b00, 1'b0); tick();
        chk("to_err_clr", 32'(bus.skew_err), 32'h0);
        drive(16'hC35A, 2'b11, 1'b0); tick();
        chk("to_relock", 32'(bus.word_out), 32'hC35A);
        drive(16'hC35B, 2'b11, 1'b1); tick();
        chk("to_pd_vld", 32'(bus.word_vld), 32'h0);

        // packet_done during ALIGN: back to IDLE quietly
        drive(16'h0060, 2'b01, 1'b0); tick();
        drive(16'h0061, 2'b01, 1'b1); tick();
        chk("al_pd_err", 32'(bus.skew_err), 32'h0);
        chk("al_pd_wfs", 32'(bus.wait_for_sync), 32'h1);
        drive(16'h0, 2'b00, 1'b0); tick();
        chk("al_pd_vld", 32'(bus.word_vld), 32'h0);

        // Reset mid-ALIGN, then a fresh one-cycle-skew lock
        drive(16'h0070, 2'b01, 1'b0); tick();
        drive(16'h0071, 2'b01, 1'b0); tick();
        reset = 1'b1; tick();
        chk("mid_rst_vld",  32'(bus.word_vld), 32'h0);
        chk("mid_rst_err",  32'(bus.skew_err), 32'h0);
        chk("mid_rst_wfs",  32'(bus.wait_for_sync), 32'h1);
        chk("mid_rst_word", 32'(bus.word_out), 32'h0);
        reset = 1'b0;
        drive(16'h0030, 2'b01, 1'b0); tick();
        drive(16'h4031, 2'b11, 1'b0); tick();
        chk("post_rst_word", 32'(bus.word_out), 32'h4030);
        chk("post_rst_vld",  32'(bus.word_vld), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
